trigger_gen: RTL and testbench

Parametrised next-generation actor trigger. It repeatedly launches one HLS actor while the actor makes progress, and it can retry a configurable number of times before declaring the actor idle. It takes part in the network-wide sleep and sync handshake with the sibling triggers, and it exposes saturating firing and sync-round counters for host profiling. One instance sits beside each actor in the generated network top and is wired to the shared all_sleep, all_sync and all_sync_wait reductions.

---
 rtl/trigger_gen_pkg.sv | 28 ++
 rtl/trigger_gen_sat.sv | 37 +++
 rtl/trigger_gen.sv | 161 ++++++++++++++++
 tb/tb_trigger_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/trigger_gen_pkg.sv
// Shared types and helpers for the actor trigger: FSM encoding, return codes
// and sizing of the retry counter.
package trigger_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LAUNCH      = 3'd1,
        S_CHECK       = 3'd2,
        S_SLEEP       = 3'd3,
        S_SYNC_LAUNCH = 3'd4,
        S_SYNC_CHECK  = 3'd5,
        S_SYNC_WAIT   = 3'd6,
        S_SYNC_EXEC   = 3'd7
    } state_t;

    // Actor return code meaning "fired and consumed/produced tokens".
    localparam int unsigned EXECUTED_CODE = 1;

    // Width of a counter able to hold 0..n, never narrower than one bit.
    function automatic int retry_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic logic [31:0] executed_code32();
        return 32'(EXECUTED_CODE);
    endfunction

endpackage

// File: rtl/trigger_gen_sat.sv
// Registered up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == {W{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/trigger_gen.sv
// Actor trigger: relaunches an HLS actor while it makes progress, retries a
// bounded number of times, then joins the network-wide sleep/sync handshake.
module trigger_gen
    import trigger_gen_pkg::*;
#(
    parameter int SYNC_ENABLE  = 1,
    parameter int RETURN_WIDTH = 32,
    parameter int NUM_ENQ      = 1,
    parameter int IDLE_RETRIES = 0,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_ready,
    output logic                    ap_idle,
    input  logic [NUM_ENQ-1:0]      external_enqueue,
    input  logic                    all_sync,
    input  logic                    all_sync_wait,
    input  logic                    all_sleep,
    output logic                    sleep,
    output logic                    sync_exec,
    output logic                    sync_wait,
    input  logic [RETURN_WIDTH-1:0] actor_return,
    input  logic                    actor_done,
    input  logic                    actor_ready,
    input  logic                    actor_idle,
    output logic                    actor_start,
    output logic [CNT_WIDTH-1:0]    fire_count,
    output logic [CNT_WIDTH-1:0]    sync_rounds
);

    localparam int RW = retry_w(IDLE_RETRIES);
    localparam logic [RW-1:0] RETRY_MAX = RW'(IDLE_RETRIES);
    localparam logic [RETURN_WIDTH-1:0] EXECUTED = RETURN_WIDTH'(EXECUTED_CODE);
    localparam logic SYNC_ON = (SYNC_ENABLE != 0);
    localparam state_t TRY_SLEEP = SYNC_ON ? S_SLEEP : S_IDLE;

    state_t        state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;

    logic enq;
    logic exec;
    logic exhausted;
    logic in_fire_state;
    logic cnt_clr;
    logic sync_inc;
    logic fire_inc;

    // Handshake inputs kept only for port compatibility with the HLS actor.
    logic unused_actor_hs;
    assign unused_actor_hs = ^{actor_ready, actor_idle};

    assign enq       = |external_enqueue;
    assign exec      = actor_done && (actor_return == EXECUTED);
    assign exhausted = actor_done && !exec && !enq && (retry_q == RETRY_MAX);

    assign in_fire_state = (state_q == S_LAUNCH) || (state_q == S_CHECK) ||
                           (state_q == S_SYNC_LAUNCH) || (state_q == S_SYNC_CHECK);
    assign fire_inc      = exec && in_fire_state;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        cnt_clr  = 1'b0;
        sync_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_LAUNCH;
                    cnt_clr = 1'b1;
                end
            end
            S_LAUNCH, S_CHECK: begin
                if (exec || enq) begin
                    state_d = S_LAUNCH;
                    retry_d = '0;
                end else if (exhausted) begin
                    state_d = TRY_SLEEP;
                    retry_d = '0;
                end else if (actor_done) begin
                    state_d = S_LAUNCH;
                    retry_d = retry_q + {{(RW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_SLEEP: begin
                if (!SYNC_ON) begin
                    state_d = S_IDLE;
                end else if (all_sleep) begin
                    state_d  = S_SYNC_LAUNCH;
                    sync_inc = 1'b1;
                end
            end
            S_SYNC_LAUNCH, S_SYNC_CHECK: begin
                if (!SYNC_ON) begin
                    state_d = S_IDLE;
                end else if (actor_done) begin
                    state_d = exec ? S_SYNC_EXEC : S_SYNC_WAIT;
                end else begin
                    state_d = S_SYNC_CHECK;
                end
            end
            S_SYNC_WAIT: begin
                if (!SYNC_ON) begin
                    state_d = S_IDLE;
                end else if (all_sync) begin
                    state_d = all_sync_wait ? S_IDLE : S_LAUNCH;
                end
            end
            S_SYNC_EXEC: begin
                if (!SYNC_ON) begin
                    state_d = S_IDLE;
                end else if (all_sync) begin
                    state_d = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                retry_d = '0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_fire_cnt (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (fire_inc),
        .q_o    (fire_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_sync_cnt (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (sync_inc),
        .q_o    (sync_rounds)
    );

    assign ap_done     = (state_q != S_IDLE) && (state_d == S_IDLE);
    assign ap_ready    = ap_done;
    assign ap_idle     = (state_q == S_IDLE);
    assign actor_start = (state_q == S_LAUNCH) || (state_q == S_SYNC_LAUNCH);
    assign sleep       = SYNC_ON && (state_q == S_SLEEP);
    assign sync_exec   = SYNC_ON && (state_q == S_SYNC_EXEC);
    assign sync_wait   = SYNC_ON && (state_q == S_SYNC_WAIT);

endmodule

// File: tb/tb_trigger_gen.sv
// Directed bench for trigger_gen: three instances with different parameter
// sets share stimulus; each scenario checks the instance it targets.
module tb_trigger_gen;
    import trigger_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic [3:0]  enq4;
    logic        all_sync, all_sync_wait, all_sleep;
    logic [31:0] actor_return;
    logic        actor_done;

    logic        done_a, ready_a, idle_a, sleep_a, sexec_a, swait_a, start_a;
    logic [31:0] fire_a, rounds_a;
    logic        done_b, ready_b, idle_b, sleep_b, sexec_b, swait_b, start_b;
    logic [31:0] fire_b, rounds_b;
    logic        done_c, ready_c, idle_c, sleep_c, sexec_c, swait_c, start_c;
    logic [3:0]  fire_c, rounds_c;

    int n_checks = 0;
    int n_fail   = 0;
    int starts;

    logic [31:0] RET_EXEC;
    logic [31:0] RET_NONE;

    always #5 clk = ~clk;

    trigger_gen #(.SYNC_ENABLE(1), .RETURN_WIDTH(32), .NUM_ENQ(4), .IDLE_RETRIES(0), .CNT_WIDTH(32)) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(done_a), .ap_ready(ready_a),
        .ap_idle(idle_a), .external_enqueue(enq4), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
        .all_sleep(all_sleep), .sleep(sleep_a), .sync_exec(sexec_a), .sync_wait(swait_a),
        .actor_return(actor_return), .actor_done(actor_done), .actor_ready(1'b0), .actor_idle(1'b0),
        .actor_start(start_a), .fire_count(fire_a), .sync_rounds(rounds_a));

    trigger_gen #(.SYNC_ENABLE(1), .RETURN_WIDTH(32), .NUM_ENQ(1), .IDLE_RETRIES(2), .CNT_WIDTH(32)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(done_b), .ap_ready(ready_b),
        .ap_idle(idle_b), .external_enqueue(enq4[0:0]), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
        .all_sleep(all_sleep), .sleep(sleep_b), .sync_exec(sexec_b), .sync_wait(swait_b),
        .actor_return(actor_return), .actor_done(actor_done), .actor_ready(1'b0), .actor_idle(1'b0),
        .actor_start(start_b), .fire_count(fire_b), .sync_rounds(rounds_b));

    trigger_gen #(.SYNC_ENABLE(0), .RETURN_WIDTH(32), .NUM_ENQ(1), .IDLE_RETRIES(0), .CNT_WIDTH(4)) dut_c (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(done_c), .ap_ready(ready_c),
        .ap_idle(idle_c), .external_enqueue(enq4[0:0]), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
        .all_sleep(all_sleep), .sleep(sleep_c), .sync_exec(sexec_c), .sync_wait(swait_c),
        .actor_return(actor_return), .actor_done(actor_done), .actor_ready(1'b0), .actor_idle(1'b0),
        .actor_start(start_c), .fire_count(fire_c), .sync_rounds(rounds_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ap_start = 1'b0; enq4 = 4'b0; actor_done = 1'b0; actor_return = '0;
        all_sync = 1'b0; all_sync_wait = 1'b0; all_sleep = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic start_run();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        #1;
    endtask

    // From LAUNCH: one idle CHECK cycle, then present the return and settle.
    task automatic fire(input logic [31:0] ret, input logic [3:0] enq);
        actor_done = 1'b0;
        tick();
        actor_done = 1'b1; actor_return = ret; enq4 = enq;
        #1;
    endtask

    task automatic finish_ret();
        tick();
        actor_done = 1'b0; enq4 = 4'b0; actor_return = '0;
        #1;
    endtask

    initial begin
        RET_EXEC = executed_code32();
        RET_NONE = RET_EXEC + 32'd1;

        // Reset values and a three-fire run into SLEEP, then the sync path
        do_reset();
        check("rst_idle", idle_a, 1);
        check("rst_start", start_a, 0);
        check("rst_done", done_a, 0);
        check("rst_fire", fire_a, 0);
        start_run();
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            if (start_a) starts++;
            fire((i < 3) ? RET_EXEC : RET_NONE, 4'b0);
            if (i == 3) check("sleep_no_done", done_a, 0);
            finish_ret();
        end
        check("a_sleep", sleep_a, 1);
        check("a_fire3", fire_a, 3);
        check("a_starts4", starts, 4);
        check("a_sleep_hold", start_a, 0);
        all_sleep = 1'b1;
        tick();
        all_sleep = 1'b0;
        #1;
        check("sync_launch_start", start_a, 1);
        check("sync_rounds1", rounds_a, 1);
        actor_done = 1'b1; actor_return = RET_NONE;
        tick();
        actor_done = 1'b0;
        #1;
        check("sync_wait", swait_a, 1);
        check("sync_wait_nodone", done_a, 0);
        all_sync = 1'b1; all_sync_wait = 1'b1;
        #1;
        check("sync_done", done_a, 1);
        check("sync_ready", ready_a, 1);
        tick();
        all_sync = 1'b0; all_sync_wait = 1'b0;
        #1;
        check("sync_idle", idle_a, 1);
        check("sync_done_1cyc", done_a, 0);
        check("hold_fire", fire_a, 3);
        check("hold_rounds", rounds_a, 1);

        // Enqueue keeps the actor running; exec with enq counts once
        do_reset();
        start_run();
        fire(RET_NONE, 4'b0100);
        finish_ret();
        check("enq_launch", start_a, 1);
        check("enq_nofire", fire_a, 0);
        check("enq_nosleep", sleep_a, 0);
        fire(RET_EXEC, 4'b0001);
        finish_ret();
        check("exec_enq_once", fire_a, 1);
        check("exec_enq_launch", start_a, 1);

        // Retry budget of two, reset by an intervening EXECUTED return
        do_reset();
        start_run();
        fire(RET_NONE, 4'b0); finish_ret();
        check("retry1_launch", start_b, 1);
        fire(RET_NONE, 4'b0); finish_ret();
        check("retry2_launch", start_b, 1);
        fire(RET_EXEC, 4'b0); finish_ret();
        check("retry_exec_fire", fire_b, 1);
        fire(RET_NONE, 4'b0); finish_ret();
        fire(RET_NONE, 4'b0); finish_ret();
        check("retry_after_exec", start_b, 1);
        check("retry_not_sleep", sleep_b, 0);
        fire(RET_NONE, 4'b0); finish_ret();
        check("retry_sleep", sleep_b, 1);

        // No-sync variant: saturation, direct exit, restart clears counters
        do_reset();
        start_run();
        for (int i = 0; i < 20; i++) begin
            fire(RET_EXEC, 4'b0);
            finish_ret();
        end
        check("sat_fire15", fire_c, 15);
        fire(RET_NONE, 4'b0);
        ap_start = 1'b1;
        #1;
        check("nosync_done", done_c, 1);
        check("nosync_sleep", sleep_c, 0);
        finish_ret();
        check("nosync_idle", idle_c, 1);
        check("nosync_start_ignored", start_c, 0);
        check("nosync_hold", fire_c, 15);
        check("nosync_rounds", rounds_c, 0);
        tick();
        ap_start = 1'b0;
        #1;
        check("restart_clear", fire_c, 0);
        check("restart_launch", start_c, 1);

        // Asynchronous reset during CHECK
        do_reset();
        start_run();
        fire(RET_EXEC, 4'b0);
        finish_ret();
        actor_done = 1'b0;
        tick();
        check("pre_rst_check", idle_a, 0);
        check("pre_rst_fire", fire_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_idle", idle_a, 1);
        check("async_start", start_a, 0);
        check("async_done", done_a, 0);
        check("async_fire", fire_a, 0);
        tick();
        check("async_hold_done", done_a, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", idle_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
